stream_syndrome_calculator: RTL

Streaming, parametrised Reed-Solomon syndrome generator for GF(2^M). It accepts one received-codeword symbol per cycle over a valid/ready handshake and updates all NSYM syndromes in parallel with Horner's rule. It presents the finished syndrome vector, plus a nonzero flag, over a second valid/ready handshake to the downstream key-equation solver. It is the successor of the serial, one-root-at-a-time syndrome stage: arbitrary symbol width, root count and first consecutive root, no whole-codeword input buffer, and back-pressure on both sides.

---
 rtl/stream_syndrome_calculator.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/stream_syndrome_calculator.sv
// rtl/stream_syndrome_calculator.sv - streaming Reed-Solomon syndrome generator over GF(2^M)
//
// Accepts one received symbol per cycle (highest-degree coefficient first) and
// updates NSYM syndromes in parallel with Horner's rule:
//   S_j <= S_j * alpha^(FCR+j) XOR in_data
// When the in_last symbol is accepted the finished vector is held on the
// syndrome port until the downstream solver takes it.
//
// Optional feature: define SYNDROME_LEN_CHECK_EN to build the codeword length
// counter that drives len_error (otherwise len_error is tied low, N unused).
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   in_valid/ready  input symbol handshake; in_data symbol, in_last end of codeword
//   syn_valid/ready syndrome vector handshake
//   syndromes_flat  S_j at bits [M*(j+1)-1 : M*j]
//   syn_nonzero     OR of all syndromes (qualified by syn_valid)
//   len_error       accepted length != N (qualified by syn_valid)
module stream_syndrome_calculator #(
  parameter int M         = 8,
  parameter int NSYM      = 32,
  parameter int PRIM_POLY = 'h11D,
  parameter int FCR       = 0,
  parameter int N         = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [M-1:0]      in_data,
  input  logic              in_last,
  output logic              syn_valid,
  input  logic              syn_ready,
  output logic [M*NSYM-1:0] syndromes_flat,
  output logic              syn_nonzero,
  output logic              len_error
);

  localparam int ORDER = (1 << M) - 1;
  localparam logic [M-1:0] POLY_LOW = PRIM_POLY[M-1:0];
  localparam logic [M-1:0] ONE = {{(M-1){1'b0}}, 1'b1};

  // Multiply by x and reduce modulo the primitive polynomial.
  function automatic logic [M-1:0] xtime(input logic [M-1:0] a);
    return a[M-1] ? ((a << 1) ^ POLY_LOW) : (a << 1);
  endfunction

  // Shift-and-add product; with one operand constant this collapses to an XOR tree.
  function automatic logic [M-1:0] gf_mul(input logic [M-1:0] a, input logic [M-1:0] b);
    logic [M-1:0] p;
    logic [M-1:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < M; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // alpha^e with alpha = x, evaluated at elaboration.
  function automatic logic [M-1:0] alpha_pow(input int e);
    logic [M-1:0] r;
    r = ONE;
    for (int i = 0; i < e; i++) r = xtime(r);
    return r;
  endfunction

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t       state;
  logic         in_ready_q;
  logic         acc_fire;
  logic         out_fire;
  logic         next_nonzero;
  logic [M-1:0] acc_q [NSYM];
  logic [M-1:0] acc_d [NSYM];

  // in_ready is a registered FSM output, forced low while rst is asserted.
  assign in_ready = in_ready_q & ~rst;
  assign acc_fire = (state == ACCUM) && in_valid;
  assign out_fire = (state == HOLD) && syn_ready;

  for (genvar j = 0; j < NSYM; j++) begin : g_root
    localparam logic [M-1:0] ROOT = alpha_pow((FCR + j) % ORDER);
    assign acc_d[j] = gf_mul(acc_q[j], ROOT) ^ in_data;
    assign syndromes_flat[M*j +: M] = acc_q[j];
  end

  always_comb begin
    next_nonzero = 1'b0;
    for (int j = 0; j < NSYM; j++) next_nonzero = next_nonzero | (|acc_d[j]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ACCUM;
      in_ready_q  <= 1'b1;
      syn_valid   <= 1'b0;
      syn_nonzero <= 1'b0;
      for (int j = 0; j < NSYM; j++) acc_q[j] <= '0;
    end else begin
      case (state)
        ACCUM: begin
          if (in_valid) begin
            for (int j = 0; j < NSYM; j++) acc_q[j] <= acc_d[j];
            syn_nonzero <= next_nonzero;
            if (in_last) begin
              state      <= HOLD;
              in_ready_q <= 1'b0;
              syn_valid  <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (syn_ready) begin
            for (int j = 0; j < NSYM; j++) acc_q[j] <= '0;
            syn_nonzero <= 1'b0;
            state       <= ACCUM;
            in_ready_q  <= 1'b1;
            syn_valid   <= 1'b0;
          end
        end
        default: begin
          state      <= ACCUM;
          in_ready_q <= 1'b1;
          syn_valid  <= 1'b0;
        end
      endcase
    end
  end

`ifdef SYNDROME_LEN_CHECK_EN
  localparam int CW = $clog2(N + 2);
  logic [CW-1:0] cnt_q;

  // Saturating so an overlong codeword can never wrap back onto N.
  always_ff @(posedge clk) begin
    if (rst || out_fire) begin
      cnt_q     <= '0;
      len_error <= 1'b0;
    end else if (acc_fire) begin
      if (cnt_q != {CW{1'b1}}) cnt_q <= cnt_q + 1'b1;
      if (in_last) len_error <= ((int'(cnt_q) + 1) != N);
    end
  end
`else
  assign len_error = 1'b0;
`endif

endmodule
